jpc_operand_fetch: RTL and testbench

Operand-fetch stage between instruction decode and execute. Accepts one decoded instruction at a time and issues read requests for rs1/rs2 on the two `jpc_regfile` ports. It collects the returned data and presents a complete operand bundle to execute over a valid/ready handshake. Register x0 is never requested; its value is produced locally as zero.

---
 rtl/jpc_operand_fetch_pkg.sv | 23 ++
 rtl/jpc_of_port.sv | 86 ++++++++
 rtl/jpc_operand_fetch.sv | 204 ++++++++++++++++++++
 tb/tb_jpc_operand_fetch.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpc_operand_fetch_pkg.sv
// Shared widths, FSM state encoding and the x0-aware read-need helper for the
// operand-fetch stage.
package jpc_operand_fetch_pkg;

    localparam int JPC_REGDATA_WIDTH = 32;
    localparam int JPC_CTRL_WIDTH    = 16;
    localparam int JPC_REG_IDX_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } of_state_e;

    // x0 reads as zero, so it never costs a regfile request.
    function automatic logic port_needed(input logic                         use_reg,
                                         input logic [JPC_REG_IDX_WIDTH-1:0] idx);
        return use_reg && (idx != '0);
    endfunction

endpackage

// File: rtl/jpc_of_port.sv
// One regfile read port of the operand-fetch stage: request/response flags,
// operand data register and the idx_valid / rdata_ready strobes.
module jpc_of_port
    import jpc_operand_fetch_pkg::*;
#(
    parameter int DW = JPC_REGDATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_need,
    input  logic [JPC_REG_IDX_WIDTH-1:0] i_idx,
    input  logic                         i_clear,
    input  logic                         i_req_en,
    input  logic                         i_rsp_en,
    input  logic                         i_keep_data,
    input  logic                         i_idx_ready,
    input  logic                         i_rdata_valid,
    input  logic [DW-1:0]                i_rdata,
    output logic                         o_idx_valid,
    output logic [JPC_REG_IDX_WIDTH-1:0] o_idx,
    output logic                         o_rdata_ready,
    output logic [DW-1:0]                o_data,
    output logic                         o_all_sent,
    output logic                         o_all_recv,
    output logic                         o_outstanding
);

    logic                         r_need;
    logic                         r_sent;
    logic                         r_recv;
    logic [JPC_REG_IDX_WIDTH-1:0] r_idx;
    logic [DW-1:0]                r_data;

    logic w_send;
    logic w_take;
    logic w_sent_next;
    logic w_recv_next;

    assign o_idx_valid   = i_req_en && r_need && !r_sent;
    assign o_rdata_ready = i_rsp_en && r_sent && !r_recv;
    assign w_send        = o_idx_valid && i_idx_ready;
    assign w_take        = o_rdata_ready && i_rdata_valid;
    assign w_sent_next   = r_sent || w_send;
    assign w_recv_next   = r_recv || w_take;

    // Status includes this cycle's handshakes so the FSM can advance without
    // waiting an extra cycle for the flags to settle.
    assign o_all_sent    = !r_need || w_sent_next;
    assign o_all_recv    = !r_need || w_recv_next;
    assign o_outstanding = w_sent_next && !w_recv_next;

    assign o_idx  = r_idx;
    assign o_data = r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_need <= 1'b0;
            r_sent <= 1'b0;
            r_recv <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
        end else if (i_load) begin
            r_need <= i_need;
            r_sent <= 1'b0;
            r_recv <= 1'b0;
            r_idx  <= i_idx;
            r_data <= '0;
        end else if (i_clear) begin
            r_need <= 1'b0;
            r_sent <= 1'b0;
            r_recv <= 1'b0;
        end else begin
            if (w_send) begin
                r_sent <= 1'b1;
            end
            if (w_take) begin
                r_recv <= 1'b1;
                if (i_keep_data) begin
                    r_data <= i_rdata;
                end
            end
        end
    end

endmodule

// File: rtl/jpc_operand_fetch.sv
// Operand-fetch stage: accepts a decoded instruction, reads rs1/rs2 from the
// two regfile ports and hands a complete operand bundle to execute.
module jpc_operand_fetch
    import jpc_operand_fetch_pkg::*;
#(
    parameter int DW = JPC_REGDATA_WIDTH,
    parameter int CW = JPC_CTRL_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_valid_I,
    output logic          dec_ready_O,
    input  logic [4:0]    dec_rs1_I,
    input  logic [4:0]    dec_rs2_I,
    input  logic [4:0]    dec_rd_I,
    input  logic          dec_use_rs1_I,
    input  logic          dec_use_rs2_I,
    input  logic [DW-1:0] dec_imm_I,
    input  logic [CW-1:0] dec_ctrl_I,
    output logic          rf1_idx_op_O,
    output logic [4:0]    rf1_idx_O,
    output logic          rf1_idx_valid_O,
    input  logic          rf1_idx_ready_I,
    output logic          rf1_rdata_ready_O,
    input  logic [DW-1:0] rf1_rdata_I,
    input  logic          rf1_rdata_valid_I,
    output logic          rf2_idx_op_O,
    output logic [4:0]    rf2_idx_O,
    output logic          rf2_idx_valid_O,
    input  logic          rf2_idx_ready_I,
    output logic          rf2_data_ready_O,
    input  logic [DW-1:0] rf2_data_I,
    input  logic          rf2_data_valid_I,
    output logic          ex_valid_O,
    input  logic          ex_ready_I,
    output logic [DW-1:0] ex_rs1_val_O,
    output logic [DW-1:0] ex_rs2_val_O,
    output logic [DW-1:0] ex_imm_O,
    output logic [4:0]    ex_rd_O,
    output logic [CW-1:0] ex_ctrl_O,
    input  logic          flush_I
);

    of_state_e     r_state;
    of_state_e     w_state_next;
    logic          r_dec_ready;
    logic          r_ex_valid;
    logic [4:0]    r_rd;
    logic [DW-1:0] r_imm;
    logic [CW-1:0] r_ctrl;

    logic          w_accept;
    logic          w_clear;
    logic          w_req_en;
    logic          w_rsp_en;
    logic          w_keep;
    logic          w_any_out;
    of_state_e     w_accept_state;

    logic [1:0]    w_need;
    logic [1:0]    w_idx_ready;
    logic [1:0]    w_rdata_valid;
    logic [1:0]    w_idx_valid;
    logic [1:0]    w_rdata_ready;
    logic [1:0]    w_all_sent;
    logic [1:0]    w_all_recv;
    logic [1:0]    w_outstanding;
    logic [4:0]    w_dec_idx [2];
    logic [4:0]    w_rf_idx  [2];
    logic [DW-1:0] w_rdata   [2];
    logic [DW-1:0] w_data    [2];

    assign w_need[0]      = port_needed(dec_use_rs1_I, dec_rs1_I);
    assign w_need[1]      = port_needed(dec_use_rs2_I, dec_rs2_I);
    assign w_dec_idx[0]   = dec_rs1_I;
    assign w_dec_idx[1]   = dec_rs2_I;
    assign w_idx_ready    = {rf2_idx_ready_I, rf1_idx_ready_I};
    assign w_rdata_valid  = {rf2_data_valid_I, rf1_rdata_valid_I};
    assign w_rdata[0]     = rf1_rdata_I;
    assign w_rdata[1]     = rf2_data_I;
    assign w_any_out      = |w_outstanding;
    assign w_accept_state = (|w_need) ? ST_REQ : ST_OUT;

    // A sent port keeps listening for its response while the other port is
    // still requesting, and keeps draining after a flush.
    assign w_req_en = (r_state == ST_REQ);
    assign w_rsp_en = (r_state == ST_REQ) || (r_state == ST_RESP) || (r_state == ST_DRAIN);
    assign w_keep   = (r_state != ST_DRAIN);
    assign w_clear  = (w_state_next == ST_IDLE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            jpc_of_port #(
                .DW(DW)
            ) u_port (
                .clk          (clk),
                .rst          (rst),
                .i_load       (w_accept),
                .i_need       (w_need[gi]),
                .i_idx        (w_dec_idx[gi]),
                .i_clear      (w_clear),
                .i_req_en     (w_req_en),
                .i_rsp_en     (w_rsp_en),
                .i_keep_data  (w_keep),
                .i_idx_ready  (w_idx_ready[gi]),
                .i_rdata_valid(w_rdata_valid[gi]),
                .i_rdata      (w_rdata[gi]),
                .o_idx_valid  (w_idx_valid[gi]),
                .o_idx        (w_rf_idx[gi]),
                .o_rdata_ready(w_rdata_ready[gi]),
                .o_data       (w_data[gi]),
                .o_all_sent   (w_all_sent[gi]),
                .o_all_recv   (w_all_recv[gi]),
                .o_outstanding(w_outstanding[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (flush_I) begin
            if (r_state != ST_IDLE) begin
                w_state_next = w_any_out ? ST_DRAIN : ST_IDLE;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (r_dec_ready && dec_valid_I) begin
                        w_accept     = 1'b1;
                        w_state_next = w_accept_state;
                    end
                end
                ST_REQ: begin
                    if (&w_all_sent) begin
                        w_state_next = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (&w_all_recv) begin
                        w_state_next = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (ex_ready_I) begin
                        if (dec_valid_I) begin
                            w_accept     = 1'b1;
                            w_state_next = w_accept_state;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!w_any_out) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_dec_ready <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_ctrl      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_dec_ready <= (w_state_next == ST_IDLE);
            r_ex_valid  <= (w_state_next == ST_OUT);
            if (w_accept) begin
                r_rd   <= dec_rd_I;
                r_imm  <= dec_imm_I;
                r_ctrl <= dec_ctrl_I;
            end
        end
    end

    // In OUT the decode handshake follows execute so a new instruction can
    // be taken in the same cycle the current bundle is consumed.
    assign dec_ready_O       = (r_state == ST_OUT) ? ex_ready_I : r_dec_ready;

    assign rf1_idx_op_O      = 1'b0;
    assign rf2_idx_op_O      = 1'b0;
    assign rf1_idx_O         = w_rf_idx[0];
    assign rf2_idx_O         = w_rf_idx[1];
    assign rf1_idx_valid_O   = w_idx_valid[0];
    assign rf2_idx_valid_O   = w_idx_valid[1];
    assign rf1_rdata_ready_O = w_rdata_ready[0];
    assign rf2_data_ready_O  = w_rdata_ready[1];

    assign ex_valid_O        = r_ex_valid;
    assign ex_rs1_val_O      = w_data[0];
    assign ex_rs2_val_O      = w_data[1];
    assign ex_imm_O          = r_imm;
    assign ex_rd_O           = r_rd;
    assign ex_ctrl_O         = r_ctrl;

endmodule

// File: tb/tb_jpc_operand_fetch.sv
// Directed bench for jpc_operand_fetch with a small two-port regfile model that
// answers one cycle after each accepted request.
module tb_jpc_operand_fetch;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dec_valid_I, dec_ready_O;
    logic [4:0]    dec_rs1_I, dec_rs2_I, dec_rd_I;
    logic          dec_use_rs1_I, dec_use_rs2_I;
    logic [DW-1:0] dec_imm_I;
    logic [CW-1:0] dec_ctrl_I;
    logic          rf1_idx_op_O, rf1_idx_valid_O, rf1_idx_ready_I, rf1_rdata_ready_O, rf1_rdata_valid_I;
    logic [4:0]    rf1_idx_O;
    logic [DW-1:0] rf1_rdata_I;
    logic          rf2_idx_op_O, rf2_idx_valid_O, rf2_idx_ready_I, rf2_data_ready_O, rf2_data_valid_I;
    logic [4:0]    rf2_idx_O;
    logic [DW-1:0] rf2_data_I;
    logic          ex_valid_O, ex_ready_I, flush_I;
    logic [DW-1:0] ex_rs1_val_O, ex_rs2_val_O, ex_imm_O;
    logic [4:0]    ex_rd_O;
    logic [CW-1:0] ex_ctrl_O;

    int n_run  = 0;
    int n_fail = 0;

    jpc_operand_fetch #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid_I(dec_valid_I), .dec_ready_O(dec_ready_O),
        .dec_rs1_I(dec_rs1_I), .dec_rs2_I(dec_rs2_I), .dec_rd_I(dec_rd_I),
        .dec_use_rs1_I(dec_use_rs1_I), .dec_use_rs2_I(dec_use_rs2_I),
        .dec_imm_I(dec_imm_I), .dec_ctrl_I(dec_ctrl_I),
        .rf1_idx_op_O(rf1_idx_op_O), .rf1_idx_O(rf1_idx_O), .rf1_idx_valid_O(rf1_idx_valid_O),
        .rf1_idx_ready_I(rf1_idx_ready_I), .rf1_rdata_ready_O(rf1_rdata_ready_O),
        .rf1_rdata_I(rf1_rdata_I), .rf1_rdata_valid_I(rf1_rdata_valid_I),
        .rf2_idx_op_O(rf2_idx_op_O), .rf2_idx_O(rf2_idx_O), .rf2_idx_valid_O(rf2_idx_valid_O),
        .rf2_idx_ready_I(rf2_idx_ready_I), .rf2_data_ready_O(rf2_data_ready_O),
        .rf2_data_I(rf2_data_I), .rf2_data_valid_I(rf2_data_valid_I),
        .ex_valid_O(ex_valid_O), .ex_ready_I(ex_ready_I),
        .ex_rs1_val_O(ex_rs1_val_O), .ex_rs2_val_O(ex_rs2_val_O), .ex_imm_O(ex_imm_O),
        .ex_rd_O(ex_rd_O), .ex_ctrl_O(ex_ctrl_O), .flush_I(flush_I)
    );

    always #5 clk = ~clk;

    // Regfile model: a request is answered from the next cycle on, held until
    // taken; rfN_hold withholds the response to create outstanding reads.
    logic [DW-1:0] mem [32];
    logic          p1_pend, p2_pend, rf1_hold, rf2_hold;
    logic [4:0]    p1_idx, p2_idx;
    int            req1_cnt = 0;
    int            req2_cnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_pend <= 1'b0;
            p1_idx  <= '0;
        end else begin
            if (rf1_rdata_valid_I && rf1_rdata_ready_O) p1_pend <= 1'b0;
            if (rf1_idx_valid_O && rf1_idx_ready_I) begin
                p1_pend  <= 1'b1;
                p1_idx   <= rf1_idx_O;
                req1_cnt <= req1_cnt + 1;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p2_pend <= 1'b0;
            p2_idx  <= '0;
        end else begin
            if (rf2_data_valid_I && rf2_data_ready_O) p2_pend <= 1'b0;
            if (rf2_idx_valid_O && rf2_idx_ready_I) begin
                p2_pend  <= 1'b1;
                p2_idx   <= rf2_idx_O;
                req2_cnt <= req2_cnt + 1;
            end
        end
    end

    assign rf1_rdata_valid_I = p1_pend && !rf1_hold;
    assign rf1_rdata_I       = mem[p1_idx];
    assign rf2_data_valid_I  = p2_pend && !rf2_hold;
    assign rf2_data_I        = mem[p2_idx];

    task automatic drive_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic u1, input logic u2,
                             input logic [DW-1:0] imm, input logic [CW-1:0] ctrl);
        dec_valid_I   = 1'b1;
        dec_rs1_I     = rs1;
        dec_rs2_I     = rs2;
        dec_rd_I      = rd;
        dec_use_rs1_I = u1;
        dec_use_rs2_I = u2;
        dec_imm_I     = imm;
        dec_ctrl_I    = ctrl;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_run++;
        if (dec_ready_O !== 1'b0) begin
            n_fail++; $display("FAIL reset_dec_ready: got %0b want 0", dec_ready_O);
        end
        n_run++;
        if ({ex_valid_O, rf1_idx_valid_O, rf2_idx_valid_O, ex_rs1_val_O, ex_rd_O} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: ex_valid=%0b idx_v=%0b%0b rs1=%h rd=%0d want all 0",
                               ex_valid_O, rf1_idx_valid_O, rf2_idx_valid_O, ex_rs1_val_O, ex_rd_O);
        end
        rst = 1'b1;
        @(negedge clk);
        n_run++;
        if (dec_ready_O !== 1'b1 || ex_valid_O !== 1'b0 || rf1_idx_valid_O !== 1'b0 || rf1_idx_op_O !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: dec_ready=%0b ex_valid=%0b rf1_idx_valid=%0b op=%0b want 1 0 0 0",
                               dec_ready_O, ex_valid_O, rf1_idx_valid_O, rf1_idx_op_O);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_two_reads();
        int c1, c2;
        c1 = req1_cnt; c2 = req2_cnt;
        drive_dec(5'd5, 5'd7, 5'd3, 1'b1, 1'b1, 32'hCAFE0001, 16'hA5A5);
        @(negedge clk); dec_valid_I = 1'b0;
        n_run++;
        if (ex_valid_O !== 1'b0 || rf1_idx_valid_O !== 1'b1 || rf2_idx_valid_O !== 1'b1
            || rf1_idx_O !== 5'd5 || rf2_idx_O !== 5'd7) begin
            n_fail++; $display("FAIL two_reads_req: ex_valid=%0b idx_v=%0b%0b idx=%0d/%0d want 0 11 5/7",
                               ex_valid_O, rf1_idx_valid_O, rf2_idx_valid_O, rf1_idx_O, rf2_idx_O);
        end
        @(negedge clk);
        n_run++;
        if (ex_valid_O !== 1'b0 || rf1_rdata_ready_O !== 1'b1 || rf2_data_ready_O !== 1'b1) begin
            n_fail++; $display("FAIL two_reads_resp: ex_valid=%0b rdy=%0b%0b want 0 11",
                               ex_valid_O, rf1_rdata_ready_O, rf2_data_ready_O);
        end
        @(negedge clk);
        n_run++;
        if (ex_valid_O !== 1'b1 || ex_rs1_val_O !== 32'hDEADBEEF || ex_rs2_val_O !== 32'h12345678
            || ex_rd_O !== 5'd3 || ex_imm_O !== 32'hCAFE0001 || ex_ctrl_O !== 16'hA5A5) begin
            n_fail++; $display("FAIL two_reads_bundle: v=%0b rs1=%h rs2=%h rd=%0d imm=%h ctrl=%h want 1 deadbeef 12345678 3 cafe0001 a5a5",
                               ex_valid_O, ex_rs1_val_O, ex_rs2_val_O, ex_rd_O, ex_imm_O, ex_ctrl_O);
        end
        n_run++;
        if (req1_cnt - c1 !== 1 || req2_cnt - c2 !== 1) begin
            n_fail++; $display("FAIL two_reads_reqcount: got %0d/%0d want 1/1", req1_cnt - c1, req2_cnt - c2);
        end
        ex_ready_I = 1'b1;
        @(negedge clk); ex_ready_I = 1'b0;
        n_run++;
        if (ex_valid_O !== 1'b0 || dec_ready_O !== 1'b1) begin
            n_fail++; $display("FAIL two_reads_consume: ex_valid=%0b dec_ready=%0b want 0 1", ex_valid_O, dec_ready_O);
        end
        $display("[TB] test_two_reads: rs1=5 rs2=7 -> deadbeef/12345678");
    endtask

    task automatic test_x0();
        int c1, c2;
        c1 = req1_cnt; c2 = req2_cnt;
        drive_dec(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 32'h00000044, 16'h0004);
        @(negedge clk); dec_valid_I = 1'b0;
        n_run++;
        if (ex_valid_O !== 1'b1 || ex_rs1_val_O !== '0 || ex_rs2_val_O !== '0 || ex_rd_O !== 5'd4
            || rf1_idx_valid_O !== 1'b0 || rf2_idx_valid_O !== 1'b0) begin
            n_fail++; $display("FAIL x0_bundle: v=%0b rs1=%h rs2=%h rd=%0d idx_v=%0b%0b want 1 0 0 4 00",
                               ex_valid_O, ex_rs1_val_O, ex_rs2_val_O, ex_rd_O, rf1_idx_valid_O, rf2_idx_valid_O);
        end
        n_run++;
        if (req1_cnt != c1 || req2_cnt != c2) begin
            n_fail++; $display("FAIL x0_reqcount: got %0d/%0d want 0/0", req1_cnt - c1, req2_cnt - c2);
        end
        ex_ready_I = 1'b1;
        @(negedge clk); ex_ready_I = 1'b0;
        $display("[TB] test_x0: rs1=0 rs2=0 -> 0/0 in 1 cycle");
    endtask

    task automatic test_back_to_back();
        int c2;
        int k;
        c2 = req2_cnt;
        drive_dec(5'd5, 5'd7, 5'd10, 1'b1, 1'b1, 32'h0000000A, 16'h000A);
        @(negedge clk); dec_valid_I = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if (ex_valid_O !== 1'b1 || dec_ready_O !== 1'b0 || ex_rs1_val_O !== 32'hDEADBEEF
                || ex_rs2_val_O !== 32'h12345678 || ex_rd_O !== 5'd10) begin
                n_fail++; $display("FAIL b2b_hold[%0d]: v=%0b dec_rdy=%0b rs1=%h rs2=%h rd=%0d want 1 0 deadbeef 12345678 10",
                                   i, ex_valid_O, dec_ready_O, ex_rs1_val_O, ex_rs2_val_O, ex_rd_O);
            end
            @(negedge clk);
        end
        ex_ready_I = 1'b1;
        drive_dec(5'd7, 5'd5, 5'd11, 1'b1, 1'b0, 32'h0000000B, 16'h000B);
        #1;
        n_run++;
        if (dec_ready_O !== 1'b1) begin
            n_fail++; $display("FAIL b2b_dec_ready: got %0b want 1", dec_ready_O);
        end
        @(negedge clk); ex_ready_I = 1'b0; dec_valid_I = 1'b0;
        n_run++;
        if (ex_valid_O !== 1'b0 || dec_ready_O !== 1'b0 || rf1_idx_valid_O !== 1'b1
            || rf1_idx_O !== 5'd7 || rf2_idx_valid_O !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_req: v=%0b dec_rdy=%0b idx_v=%0b%0b idx1=%0d want 0 0 10 7",
                               ex_valid_O, dec_ready_O, rf1_idx_valid_O, rf2_idx_valid_O, rf1_idx_O);
        end
        k = 0;
        while (ex_valid_O !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_run++;
        if (k !== 2) begin
            n_fail++; $display("FAIL b2b_latency: got %0d extra cycles want 2", k);
        end
        n_run++;
        if (ex_rs1_val_O !== 32'h12345678 || ex_rs2_val_O !== '0 || ex_rd_O !== 5'd11 || ex_imm_O !== 32'h0000000B) begin
            n_fail++; $display("FAIL b2b_second_bundle: rs1=%h rs2=%h rd=%0d imm=%h want 12345678 0 11 b",
                               ex_rs1_val_O, ex_rs2_val_O, ex_rd_O, ex_imm_O);
        end
        n_run++;
        if (req2_cnt - c2 !== 1) begin
            n_fail++; $display("FAIL b2b_rf2_reqcount: got %0d want 1", req2_cnt - c2);
        end
        ex_ready_I = 1'b1;
        @(negedge clk); ex_ready_I = 1'b0;
        $display("[TB] test_back_to_back: held 5 cycles, second rs1=7 -> 12345678");
    endtask

    task automatic test_idx_stall();
        int c1, c2;
        int k;
        c1 = req1_cnt; c2 = req2_cnt;
        rf2_idx_ready_I = 1'b0;
        drive_dec(5'd7, 5'd5, 5'd12, 1'b1, 1'b1, 32'h0000000C, 16'h000C);
        @(negedge clk); dec_valid_I = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (rf2_idx_valid_O !== 1'b1 || ex_valid_O !== 1'b0) begin
                n_fail++; $display("FAIL stall_wait[%0d]: rf2_idx_valid=%0b ex_valid=%0b want 1 0",
                                   i, rf2_idx_valid_O, ex_valid_O);
            end
            @(negedge clk);
        end
        n_run++;
        if (req1_cnt - c1 !== 1 || req2_cnt != c2 || rf1_idx_valid_O !== 1'b0 || rf1_rdata_ready_O !== 1'b0) begin
            n_fail++; $display("FAIL stall_port1_done: req=%0d/%0d idx_v1=%0b rdy1=%0b want 1/0 0 0",
                               req1_cnt - c1, req2_cnt - c2, rf1_idx_valid_O, rf1_rdata_ready_O);
        end
        rf2_idx_ready_I = 1'b1;
        k = 0;
        while (ex_valid_O !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_run++;
        if (ex_valid_O !== 1'b1) begin
            n_fail++; $display("FAIL stall_timeout: ex_valid=%0b want 1 within 10 cycles", ex_valid_O);
        end
        n_run++;
        if (ex_rs1_val_O !== 32'h12345678 || ex_rs2_val_O !== 32'hDEADBEEF || ex_rd_O !== 5'd12
            || req1_cnt - c1 !== 1 || req2_cnt - c2 !== 1) begin
            n_fail++; $display("FAIL stall_bundle: rs1=%h rs2=%h rd=%0d req=%0d/%0d want 12345678 deadbeef 12 1/1",
                               ex_rs1_val_O, ex_rs2_val_O, ex_rd_O, req1_cnt - c1, req2_cnt - c2);
        end
        ex_ready_I = 1'b1;
        @(negedge clk); ex_ready_I = 1'b0;
        $display("[TB] test_idx_stall: rf2 stalled 4 cycles, operands 12345678/deadbeef");
    endtask

    task automatic test_flush();
        int c1;
        int k;
        c1 = req1_cnt;
        rf1_hold = 1'b1;
        drive_dec(5'd5, 5'd0, 5'd13, 1'b1, 1'b0, 32'h0000000D, 16'h000D);
        @(negedge clk); dec_valid_I = 1'b0;
        @(negedge clk);
        n_run++;
        if (rf1_rdata_ready_O !== 1'b1 || ex_valid_O !== 1'b0) begin
            n_fail++; $display("FAIL flush_pre: rdy1=%0b ex_valid=%0b want 1 0", rf1_rdata_ready_O, ex_valid_O);
        end
        flush_I = 1'b1;
        @(negedge clk); flush_I = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_run++;
            if (ex_valid_O !== 1'b0 || dec_ready_O !== 1'b0 || rf1_rdata_ready_O !== 1'b1 || rf1_idx_valid_O !== 1'b0) begin
                n_fail++; $display("FAIL flush_drain[%0d]: ex_valid=%0b dec_rdy=%0b rdy1=%0b idx_v1=%0b want 0 0 1 0",
                                   i, ex_valid_O, dec_ready_O, rf1_rdata_ready_O, rf1_idx_valid_O);
            end
            @(negedge clk);
        end
        rf1_hold = 1'b0;
        @(negedge clk);
        n_run++;
        if (dec_ready_O !== 1'b1 || ex_valid_O !== 1'b0 || rf1_rdata_ready_O !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: dec_rdy=%0b ex_valid=%0b rdy1=%0b want 1 0 0",
                               dec_ready_O, ex_valid_O, rf1_rdata_ready_O);
        end
        drive_dec(5'd7, 5'd5, 5'd14, 1'b1, 1'b1, 32'h0000000E, 16'h000E);
        @(negedge clk); dec_valid_I = 1'b0;
        k = 0;
        while (ex_valid_O !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_run++;
        if (ex_valid_O !== 1'b1 || ex_rs1_val_O !== 32'h12345678 || ex_rs2_val_O !== 32'hDEADBEEF
            || ex_rd_O !== 5'd14 || req1_cnt - c1 !== 2) begin
            n_fail++; $display("FAIL flush_next: v=%0b rs1=%h rs2=%h rd=%0d req1=%0d want 1 12345678 deadbeef 14 2",
                               ex_valid_O, ex_rs1_val_O, ex_rs2_val_O, ex_rd_O, req1_cnt - c1);
        end
        ex_ready_I = 1'b1;
        @(negedge clk); ex_ready_I = 1'b0;
        $display("[TB] test_flush: drained port 1, next instruction 12345678/deadbeef");
    endtask

    task automatic test_no_read_stream();
        logic [DW-1:0] imms [3];
        int c1, c2;
        imms[0] = 32'h11110000; imms[1] = 32'h22220000; imms[2] = 32'h33330000;
        c1 = req1_cnt; c2 = req2_cnt;
        drive_dec(5'd5, 5'd7, 5'd20, 1'b0, 1'b0, imms[0], 16'h0014);
        @(negedge clk);
        ex_ready_I = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if (ex_valid_O !== 1'b1 || ex_imm_O !== imms[i] || ex_rs1_val_O !== '0 || ex_rs2_val_O !== '0) begin
                n_fail++; $display("FAIL stream[%0d]: v=%0b imm=%h rs1=%h rs2=%h want 1 %h 0 0",
                                   i, ex_valid_O, ex_imm_O, ex_rs1_val_O, ex_rs2_val_O, imms[i]);
            end
            if (i < 2) dec_imm_I = imms[i+1];
            else       dec_valid_I = 1'b0;
            @(negedge clk);
        end
        ex_ready_I = 1'b0;
        n_run++;
        if (ex_valid_O !== 1'b0 || dec_ready_O !== 1'b1 || req1_cnt != c1 || req2_cnt != c2) begin
            n_fail++; $display("FAIL stream_end: v=%0b dec_rdy=%0b req=%0d/%0d want 0 1 0/0",
                               ex_valid_O, dec_ready_O, req1_cnt - c1, req2_cnt - c2);
        end
        $display("[TB] test_no_read_stream: 3 bundles in 3 cycles");
    endtask

    task automatic test_reset_midop();
        drive_dec(5'd5, 5'd7, 5'd21, 1'b1, 1'b1, 32'h00000015, 16'h0015);
        @(negedge clk); dec_valid_I = 1'b0;
        rst = 1'b0;
        #1;
        n_run++;
        if (rf1_idx_valid_O !== 1'b0 || rf2_idx_valid_O !== 1'b0 || dec_ready_O !== 1'b0 || ex_valid_O !== 1'b0) begin
            n_fail++; $display("FAIL midop_reset: idx_v=%0b%0b dec_rdy=%0b ex_valid=%0b want 00 0 0",
                               rf1_idx_valid_O, rf2_idx_valid_O, dec_ready_O, ex_valid_O);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_run++;
        if (dec_ready_O !== 1'b1 || rf1_idx_valid_O !== 1'b0) begin
            n_fail++; $display("FAIL midop_recover: dec_rdy=%0b idx_v1=%0b want 1 0", dec_ready_O, rf1_idx_valid_O);
        end
        $display("[TB] test_reset_midop done");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h01010101 * i;
        mem[0] = 32'hBAD0BAD0;
        mem[5] = 32'hDEADBEEF;
        mem[7] = 32'h12345678;
        dec_valid_I = 1'b0; dec_rs1_I = '0; dec_rs2_I = '0; dec_rd_I = '0;
        dec_use_rs1_I = 1'b0; dec_use_rs2_I = 1'b0; dec_imm_I = '0; dec_ctrl_I = '0;
        rf1_idx_ready_I = 1'b1; rf2_idx_ready_I = 1'b1; rf1_hold = 1'b0; rf2_hold = 1'b0;
        ex_ready_I = 1'b0; flush_I = 1'b0;
        test_reset();
        test_two_reads();
        test_x0();
        test_back_to_back();
        test_idx_stall();
        test_flush();
        test_no_read_stream();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, run incomplete");
        $fatal(1);
    end

endmodule
